// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encodings for the common data bus arbiter.
//   ROB_ID_WIDTH : ROB index width; labels carry one extra bit so 0 can mean "no label"
//   VAL_WIDTH    : result value width
//   cdb_src_e    : broadcast source encoding (ALU = 0, LSB = 1)
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH = 4;
  localparam int VAL_WIDTH    = 32;
  localparam int LAB_WIDTH    = ROB_ID_WIDTH + 1;
  localparam int ENT_WIDTH    = LAB_WIDTH + VAL_WIDTH;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  function automatic logic lab_is_real(input logic [LAB_WIDTH-1:0] lab);
    return lab != '0;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO holding {label, value} results for one CDB source.
//   clk, rst_n    : clock, async active-low reset
//   push, din     : write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   clear         : synchronous empty, wins over push and pop
//   count, empty, full, head : occupancy and head-of-queue data
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once count says so.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered common data bus between the
// ALU path and the load/store buffer.
//   clk, rst_in        : clock, async active-low reset
//   rdy_in             : global enable, freezes all state when low
//   flush_in           : synchronous misprediction flush
//   alu_valid/lab/val, alu_ready : ALU result push handshake
//   lsb_valid/lab/val, lsb_ready : load/store buffer result push handshake
//   cdb_valid/lab/val/src        : registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 alu_valid,
  input  logic [LAB_WIDTH-1:0] alu_lab,
  input  logic [VAL_WIDTH-1:0] alu_val,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [LAB_WIDTH-1:0] lsb_lab,
  input  logic [VAL_WIDTH-1:0] lsb_val,
  output logic                 lsb_ready,
  output logic                 cdb_valid,
  output logic [LAB_WIDTH-1:0] cdb_lab,
  output logic [VAL_WIDTH-1:0] cdb_val,
  output logic                 cdb_src
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]        alu_count, lsb_count;
  logic                 alu_empty, lsb_empty;
  logic                 alu_full, lsb_full;
  logic [ENT_WIDTH-1:0] alu_head, lsb_head;
  logic                 alu_push, lsb_push;
  logic                 grant_alu, grant_lsb;
  logic                 active, clear;
  cdb_src_e             last_grant;

  assign active = rdy_in && !flush_in;
  assign clear  = rdy_in && flush_in;

  // Ready looks only at registered occupancy, so valid never feeds back.
  assign alu_ready = rst_in && active && !alu_full;
  assign lsb_ready = rst_in && active && !lsb_full;

  // Label-0 pushes complete the handshake but are never enqueued.
  assign alu_push = alu_valid && alu_ready && lab_is_real(alu_lab);
  assign lsb_push = lsb_valid && lsb_ready && lab_is_real(lsb_lab);

  // On a tie the source that did not win last time goes next.
  assign grant_alu = active && !alu_empty && (lsb_empty || last_grant == CDB_SRC_LSB);
  assign grant_lsb = active && !lsb_empty && (alu_empty || last_grant == CDB_SRC_ALU);

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_WIDTH)) u_alu_fifo (
    .clk   (clk),
    .rst_n (rst_in),
    .push  (alu_push),
    .pop   (grant_alu),
    .clear (clear),
    .din   ({alu_lab, alu_val}),
    .count (alu_count),
    .empty (alu_empty),
    .full  (alu_full),
    .head  (alu_head)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_WIDTH)) u_lsb_fifo (
    .clk   (clk),
    .rst_n (rst_in),
    .push  (lsb_push),
    .pop   (grant_lsb),
    .clear (clear),
    .din   ({lsb_lab, lsb_val}),
    .count (lsb_count),
    .empty (lsb_empty),
    .full  (lsb_full),
    .head  (lsb_head)
  );

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_lab    <= '0;
      cdb_val    <= '0;
      cdb_src    <= CDB_SRC_ALU;
      last_grant <= CDB_SRC_LSB;
    end else if (rdy_in) begin
      if (flush_in) begin
        cdb_valid  <= 1'b0;
        last_grant <= CDB_SRC_LSB;
      end else if (grant_alu) begin
        cdb_valid  <= 1'b1;
        {cdb_lab, cdb_val} <= alu_head;
        cdb_src    <= CDB_SRC_ALU;
        last_grant <= CDB_SRC_ALU;
      end else if (grant_lsb) begin
        cdb_valid  <= 1'b1;
        {cdb_lab, cdb_val} <= lsb_head;
        cdb_src    <= CDB_SRC_LSB;
        last_grant <= CDB_SRC_LSB;
      end else begin
        cdb_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        alu_valid, lsb_valid;
  logic [4:0]  alu_lab, lsb_lab;
  logic [31:0] alu_val, lsb_val;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid, cdb_src;
  logic [4:0]  cdb_lab;
  logic [31:0] cdb_val;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .alu_valid (alu_valid),
    .alu_lab   (alu_lab),
    .alu_val   (alu_val),
    .alu_ready (alu_ready),
    .lsb_valid (lsb_valid),
    .lsb_lab   (lsb_lab),
    .lsb_val   (lsb_val),
    .lsb_ready (lsb_ready),
    .cdb_valid (cdb_valid),
    .cdb_lab   (cdb_lab),
    .cdb_val   (cdb_val),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [4:0] al; logic [31:0] aval;
    logic lv; logic [4:0] ll; logic [31:0] lval;
    logic rdy; logic fl;
    logic cr; logic ear; logic elr;
    logic cc; logic ev; logic [4:0] el; logic [31:0] eval; logic es;
  } vec_t;

  typedef struct packed { logic [4:0] lab; logic [31:0] val; } ent_t;

  ent_t q_alu[$];
  ent_t q_lsb[$];
  bit   mon_on   = 0;
  bit   chk_alt  = 0;
  bit   have_prev = 0;
  logic prev_src = 1'b0;
  int   n_bcast  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic av, logic [4:0] al, logic [31:0] aval,
                              logic lv, logic [4:0] ll, logic [31:0] lval,
                              logic rdy, logic fl, logic cr, logic ear, logic elr,
                              logic cc, logic ev, logic [4:0] el, logic [31:0] eval, logic es);
    vec_t v;
    v.av = av; v.al = al; v.aval = aval; v.lv = lv; v.ll = ll; v.lval = lval;
    v.rdy = rdy; v.fl = fl; v.cr = cr; v.ear = ear; v.elr = elr;
    v.cc = cc; v.ev = ev; v.el = el; v.eval = eval; v.es = es;
    return v;
  endfunction

  // Stimulus-only step: drive, optionally check ready, no output check.
  function automatic vec_t drv(logic av, logic [4:0] al, logic [31:0] aval,
                               logic lv, logic [4:0] ll, logic [31:0] lval,
                               logic rdy, logic fl, logic cr, logic ear, logic elr);
    return mk(av, al, aval, lv, ll, lval, rdy, fl, cr, ear, elr, 0, 0, 0, 0, 0);
  endfunction

  // Starts just after a rising edge; ends 1 time unit after the next one.
  task automatic apply(input vec_t v, input string nm);
    alu_valid = v.av; alu_lab = v.al; alu_val = v.aval;
    lsb_valid = v.lv; lsb_lab = v.ll; lsb_val = v.lval;
    rdy_in = v.rdy; flush_in = v.fl;
    #2;
    if (v.cr) begin
      check({nm, ".alu_ready"}, alu_ready, v.ear);
      check({nm, ".lsb_ready"}, lsb_ready, v.elr);
    end
    if (mon_on) begin
      if (alu_valid && alu_ready && alu_lab != 0) q_alu.push_back({alu_lab, alu_val});
      if (lsb_valid && lsb_ready && lsb_lab != 0) q_lsb.push_back({lsb_lab, lsb_val});
    end
    @(posedge clk);
    #1;
    if (v.fl && v.rdy) begin
      q_alu.delete();
      q_lsb.delete();
    end
    if (v.cc) begin
      check({nm, ".cdb_valid"}, cdb_valid, v.ev);
      check({nm, ".cdb_lab"}, cdb_lab, v.el);
      check({nm, ".cdb_val"}, cdb_val, v.eval);
      check({nm, ".cdb_src"}, cdb_src, v.es);
    end
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) apply(drv(0,0,0, 0,0,0, 1,0, 0,0,0), nm);
  endtask

  // A result counts as consumed when it is on the bus at an enabled edge.
  always @(negedge clk) begin
    if (mon_on && rst_in && rdy_in && cdb_valid) begin
      ent_t e;
      n_bcast++;
      if (chk_alt && have_prev) check("alternation", cdb_src, !prev_src);
      have_prev = 1;
      prev_src  = cdb_src;
      if (cdb_src == 1'b0) begin
        if (q_alu.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_alu_bcast: got lab %0h expected none", cdb_lab);
        end else begin
          e = q_alu.pop_front();
          check("bc_alu_lab", cdb_lab, e.lab);
          check("bc_alu_val", cdb_val, e.val);
        end
      end else begin
        if (q_lsb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_lsb_bcast: got lab %0h expected none", cdb_lab);
        end else begin
          e = q_lsb.pop_front();
          check("bc_lsb_lab", cdb_lab, e.lab);
          check("bc_lsb_val", cdb_val, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[15];

  initial begin
    //        alu               lsb               rdy fl  cr ar lr  cc v  lab val  src
    tbl[0]  = mk(1,3,32'h11,    0,0,0,            1,0,  1,1,1,  1,0,0,0,0);
    tbl[1]  = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,1,3,32'h11,0);
    tbl[2]  = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,0,3,32'h11,0);
    tbl[3]  = mk(0,0,0,         0,0,0,            1,1,  1,0,0,  1,0,3,32'h11,0);
    tbl[4]  = mk(1,1,32'hA,     1,2,32'hB,        1,0,  1,1,1,  1,0,3,32'h11,0);
    tbl[5]  = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,1,1,32'hA,0);
    tbl[6]  = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,1,2,32'hB,1);
    tbl[7]  = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,0,2,32'hB,1);
    tbl[8]  = mk(1,0,32'h55,    0,0,0,            1,0,  1,1,1,  1,0,2,32'hB,1);
    tbl[9]  = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,0,2,32'hB,1);
    tbl[10] = mk(0,0,0,         1,5,32'h22,       1,0,  1,1,1,  1,0,2,32'hB,1);
    tbl[11] = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,1,5,32'h22,1);
    tbl[12] = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,0,5,32'h22,1);
    tbl[13] = mk(1,6,32'h33,    0,0,0,            0,0,  1,0,0,  1,0,5,32'h22,1);
    tbl[14] = mk(0,0,0,         0,0,0,            1,0,  1,1,1,  1,0,5,32'h22,1);

    rst_in = 0; rdy_in = 1; flush_in = 0;
    alu_valid = 0; alu_lab = 0; alu_val = 0;
    lsb_valid = 0; lsb_lab = 0; lsb_val = 0;
    #1;
    check("rst.cdb_valid", cdb_valid, 0);
    check("rst.cdb_lab", cdb_lab, 0);
    check("rst.cdb_val", cdb_val, 0);
    check("rst.cdb_src", cdb_src, 0);
    check("rst.alu_ready", alu_ready, 0);
    check("rst.lsb_ready", lsb_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_in = 1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: LSB offers three back-to-back while ALU stays busy.
    mon_on = 1;
    apply(drv(0,0,0, 0,0,0, 1,1, 0,0,0), "bp_flush");
    chk_alt = 1; have_prev = 0;
    apply(drv(1,5'h01,32'hA1, 1,5'h11,32'hB1, 1,0, 1,1,1), "bp_a");
    apply(drv(1,5'h02,32'hA2, 1,5'h12,32'hB2, 1,0, 1,1,1), "bp_b");
    apply(drv(1,5'h03,32'hA3, 1,5'h13,32'hB3, 1,0, 1,1,0), "bp_c");
    apply(drv(1,5'h04,32'hA4, 1,5'h13,32'hB3, 1,0, 1,0,1), "bp_d");
    idle(5, "bp_drain");
    chk_alt = 0;
    check("bp.alu_q_empty", q_alu.size(), 0);
    check("bp.lsb_q_empty", q_lsb.size(), 0);
    check("bp.bcast_count", n_bcast, 6);

    // Flush with queued results and a concurrent ALU push.
    apply(drv(1,5'h01,32'h101, 1,5'h02,32'h102, 1,0, 1,1,1), "fl_a");
    apply(drv(1,5'h03,32'h103, 1,5'h04,32'h104, 1,0, 1,1,1), "fl_b");
    apply(mk(1,5'h05,32'h105, 0,0,0, 1,1, 1,0,0, 1,0,5'h01,32'h101,0), "fl_c");
    apply(mk(0,0,0, 0,0,0, 1,0, 1,1,1, 1,0,5'h01,32'h101,0), "fl_d");
    idle(3, "fl_idle");
    check("fl.bcast_count", n_bcast, 7);

    // Stall: bus holds across five disabled cycles, then resumes.
    apply(drv(1,5'h07,32'h71, 1,5'h08,32'h81, 1,0, 1,1,1), "st_push");
    apply(mk(0,0,0, 0,0,0, 1,0, 0,0,0, 1,1,5'h07,32'h71,0), "st_first");
    for (int i = 0; i < 5; i++)
      apply(mk(1,5'h09,32'h91, 0,0,0, 0,0, 1,0,0, 1,1,5'h07,32'h71,0), $sformatf("st_hold%0d", i));
    apply(mk(0,0,0, 0,0,0, 1,0, 1,1,1, 1,1,5'h08,32'h81,1), "st_resume");
    idle(2, "st_drain");
    check("st.bcast_count", n_bcast, 9);

    // Async reset between edges while a result is on the bus.
    apply(drv(1,5'h0A,32'hAA, 1,5'h0B,32'hBB, 1,0, 0,0,0), "ar_push");
    apply(mk(0,0,0, 0,0,0, 1,0, 0,0,0, 1,1,5'h0A,32'hAA,0), "ar_first");
    #2;
    rst_in = 0;
    #1;
    check("ar.cdb_valid", cdb_valid, 0);
    check("ar.cdb_lab", cdb_lab, 0);
    check("ar.alu_ready", alu_ready, 0);
    q_alu.delete();
    q_lsb.delete();
    @(posedge clk); #1;
    rst_in = 1;
    idle(3, "ar_idle");
    check("ar.cdb_valid_after", cdb_valid, 0);
    check("ar.bcast_count", n_bcast, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the two result producers, the ALU path out of the reservation station and the load/store buffer. Each producer pushes `{label, value}` results into its own small FIFO. The block grants one result per cycle, round-robin, onto a registered broadcast bus. The reorder buffer, reservation station and load/store buffer all consume that bus, and none of them ever sees two results in the same cycle.

## Interface
- `FIFO_DEPTH`, default 2: entries per source FIFO; must be a power of two, ≥2.
- `clk`  input  1  system clock, rising edge.
- `rst_in`  input  1  asynchronous, active-low reset.
- `rdy_in`  input  1  global enable; when low, all state is frozen and no handshakes complete.
- `flush_in`  input  1  misprediction flush from the ROB; synchronous.
- `alu_valid`  input  1  ALU result offered.
- `alu_lab`  input  `ROB_ID_WIDTH+1`  ROB label of the ALU result; 0 means no label.
- `alu_val`  input  `VAL_WIDTH`  ALU result value.
- `alu_ready`  output  1  ALU push accepted this cycle if `alu_valid`.
- `lsb_valid`, `lsb_lab`, `lsb_val`, `lsb_ready`: same as the `alu_*` ports, for the load/store buffer.
- `cdb_valid`  output  1  broadcast valid.
- `cdb_lab`  output  `ROB_ID_WIDTH+1`  broadcast label.
- `cdb_val`  output  `VAL_WIDTH`  broadcast value.
- `cdb_src`  output  1  source of the broadcast: 0 = ALU, 1 = LSB.

## Operation
- **Push.** A push completes when `x_valid && x_ready` at a rising edge.
  - `x_ready = rdy_in && !flush_in && count_x < FIFO_DEPTH`. It is combinational from registered counts only and never depends on `x_valid`.
  - A push with label 0 completes the handshake but is discarded: it is not enqueued and the count is unchanged.
- **Arbitration.** Evaluated every enabled cycle on the FIFO state before this cycle's pushes.
  - Only one FIFO non-empty: that FIFO is granted.
  - Both FIFOs non-empty: the source opposite `last_grant` is granted.
  - `last_grant` is reset to LSB, so ALU wins the first tie. It updates only on a grant.
- **Grant.** The head entry is popped and loaded into the output registers: `cdb_valid <= 1`, and label, value and `src` are loaded. With no grant, `cdb_valid <= 0`. The label, value and `src` registers hold their last values.
- **Simultaneous push and pop on one FIFO.** Both happen in the same cycle. The count is unchanged and the pointers advance. A full FIFO does not accept a push in the same cycle it pops, because ready is computed from the pre-pop count.
- **Flush.** `flush_in && rdy_in` at an edge:
  - Both FIFOs are emptied: pointers and counts go to 0.
  - `cdb_valid <= 0`.
  - `last_grant <= LSB`.
  - Any concurrent push or grant is dropped.
  - Flush has priority over every other event.
- **`rdy_in` low.** Nothing changes. Outputs hold, including `cdb_valid`, and consumers must also be gated by `rdy_in`. Both ready outputs are 0.
- **Reset.** Asynchronous on the falling edge of `rst_in`.
  - Output registers: `cdb_valid`=0, `cdb_lab`=0, `cdb_val`=0, `cdb_src`=0.
  - FIFOs empty, `last_grant`=LSB.
  - `alu_ready`=`lsb_ready`=0 while `rst_in` is low. After release they equal `rdy_in && !flush_in`.
  - Reset in mid-operation discards all queued results.
- **Widths and pointers.** FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Counts are `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Minimum latency is 1 cycle: a push accepted at edge N into an empty FIFO appears on the CDB after edge N+1 when uncontested.
- Throughput is one broadcast per cycle. Under continuous contention each source gets exactly every other cycle.
- A CDB output is valid for exactly one enabled cycle per result.
- Ready and arbitration paths contain no combinational path from any `*_valid` to `cdb_*`.

## Structure
- Shared package `util.v` holds `ROB_ID_WIDTH`, `VAL_WIDTH`, and new macros `CDB_SRC_ALU` = 1'b0 and `CDB_SRC_LSB` = 1'b1.
- One sub-module, `cdb_fifo`, instantiated twice. It is a parameterised synchronous FIFO with push, pop and clear ports, an asynchronous active-low reset, and outputs count, empty, full and head data.
- The arbiter, output registers and `last_grant` live in the top level.

## Test plan
- **Lone ALU push.** Reset, then ALU pushes lab=3, val=0x11 once → the next cycle shows `cdb_valid`=1, lab=3, val=0x11, src=0; the cycle after shows `cdb_valid`=0.
- **Tie.** ALU (lab 1, 0xA) and LSB (lab 2, 0xB) push in the same cycle → the broadcasts are lab 1/src 0 and then lab 2/src 1 on consecutive cycles.
- **Backpressure.** LSB pushes 3 results back-to-back with `FIFO_DEPTH`=2 while the ALU keeps its FIFO non-empty → `lsb_ready` drops to 0 after 2 accepts. All results broadcast in strict alternation with no loss and in per-source FIFO order.
- **Flush.** Flush while both FIFOs hold 2 entries and an ALU push is concurrent → next cycle `cdb_valid`=0 and both readies are 1. No stale labels are broadcast afterwards.
- **Stall.** Hold `rdy_in`=0 for 5 cycles while `cdb_valid`=1 → outputs are unchanged and readies are 0. On release the broadcast sequence resumes exactly where it stopped.
- **Label 0 and async reset.** Push with lab=0 → handshake completes and nothing is broadcast. Assert `rst_in`=0 mid-stream between clock edges → `cdb_valid` goes to 0 immediately.
